// File: rtl/rgb_hue_seq_if.sv
// rtl/rgb_hue_seq_if.sv - control and duty-output bundle of the hue sequencer
interface rgb_hue_seq_if;
   logic       en;
   logic       restart;
   logic [6:0] bright;
   logic [9:0] duty_r;
   logic [9:0] duty_g;
   logic [9:0] duty_b;
   logic [2:0] seg;
   logic       upd;

   // Controller side: drives run controls, observes duties
   modport master (
      output en,
      output restart,
      output bright,
      input  duty_r,
      input  duty_g,
      input  duty_b,
      input  seg,
      input  upd
   );

   // Sequencer side
   modport slave (
      input  en,
      input  restart,
      input  bright,
      output duty_r,
      output duty_g,
      output duty_b,
      output seg,
      output upd
   );
endinterface

// File: rtl/rgb_hue_seq.sv
// rtl/rgb_hue_seq.sv - colour-wheel sequencer producing brightness-scaled RGB duties
module rgb_hue_seq #(
   parameter int CLK_FRE = 50_000_000,
   parameter int STEP_HZ = 100
) (
   input  logic         clk,
   input  logic         rst_n,
   rgb_hue_seq_if.slave bus
);
   localparam int            DIV       = CLK_FRE / STEP_HZ;
   localparam int            PW        = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
   localparam logic [6:0]    K_LAST    = 7'd99;
   localparam logic [6:0]    FULL      = 7'd100;
   localparam logic [2:0]    SEG_LAST  = 3'd5;

   logic [PW-1:0] pcnt;
   logic [2:0]    seg_q;
   logic [6:0]    k_q;
   logic          tick;
   logic          tick_d;
   logic [6:0]    bc;
   logic [6:0]    rise;
   logic [6:0]    fall;
   logic [6:0]    raw_r;
   logic [6:0]    raw_g;
   logic [6:0]    raw_b;
   logic [9:0]    duty_r_q;
   logic [9:0]    duty_g_q;
   logic [9:0]    duty_b_q;
   logic          upd_q;

   // raw level times clamped brightness over 100; 100*100 fits the 14-bit product
   function automatic logic [9:0] scale(input logic [6:0] raw, input logic [6:0] b);
      logic [13:0] prod;
      prod = 14'(raw) * 14'(b);
      return 10'(prod / 14'd100);
   endfunction

   assign tick = bus.en && (pcnt == PCNT_LAST);
   assign bc   = (bus.bright > FULL) ? FULL : bus.bright;
   assign rise = k_q;
   assign fall = FULL - k_q;

   // Prescaler: counts only while enabled so a paused period resumes where it stopped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (bus.restart) begin
         pcnt <= '0;
      end else if (bus.en) begin
         if (tick) pcnt <= '0;
         else      pcnt <= pcnt + 1'b1;
      end
   end

   // Hue position: 100 steps per segment, six segments per wheel; restart beats tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= '0;
         k_q   <= '0;
      end else if (bus.restart) begin
         seg_q <= '0;
         k_q   <= '0;
      end else if (tick) begin
         if (k_q == K_LAST) begin
            k_q   <= '0;
            seg_q <= (seg_q == SEG_LAST) ? 3'd0 : seg_q + 3'd1;
         end else begin
            k_q <= k_q + 7'd1;
         end
      end
   end

   // Raw per-channel level from the current segment and step
   always_comb begin
      raw_r = '0;
      raw_g = '0;
      raw_b = '0;
      case (seg_q)
         3'd0: begin raw_r = FULL; raw_g = rise; end
         3'd1: begin raw_r = fall; raw_g = FULL; end
         3'd2: begin raw_g = FULL; raw_b = rise; end
         3'd3: begin raw_g = fall; raw_b = FULL; end
         3'd4: begin raw_r = rise; raw_b = FULL; end
         3'd5: begin raw_r = FULL; raw_b = fall; end
         default: begin raw_r = '0; raw_g = '0; raw_b = '0; end
      endcase
   end

   // Duty registers refresh every clock so brightness changes land without a tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_r_q <= '0;
         duty_g_q <= '0;
         duty_b_q <= '0;
      end else begin
         duty_r_q <= scale(raw_r, bc);
         duty_g_q <= scale(raw_g, bc);
         duty_b_q <= scale(raw_b, bc);
      end
   end

   // Update strobe delayed two edges from the tick so it lines up with the new duties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_d <= 1'b0;
         upd_q  <= 1'b0;
      end else begin
         tick_d <= tick && !bus.restart;
         upd_q  <= tick_d;
      end
   end

   assign bus.duty_r = duty_r_q;
   assign bus.duty_g = duty_g_q;
   assign bus.duty_b = duty_b_q;
   assign bus.seg    = seg_q;
   assign bus.upd    = upd_q;
endmodule

// File: tb/tb_rgb_hue_seq.sv
// tb/tb_rgb_hue_seq.sv - self-checking bench for rgb_hue_seq
module tb_rgb_hue_seq;
   localparam int DIV = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   rgb_hue_seq_if bus();

   rgb_hue_seq #(.CLK_FRE(1000), .STEP_HZ(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference: enabled cycles since start, pending tick, expected outputs
   int   ecnt     = 0;
   bit   pend     = 1'b0;
   int   prev_pos = 0;
   int   m_r = 0, m_g = 0, m_b = 0;
   bit   m_upd = 1'b0;

   // level codes per segment (R,G,B): 0 = off, 1 = full, 2 = rising k, 3 = falling 100-k
   int lv [6][3] = '{'{1,2,0}, '{3,1,0}, '{0,1,2}, '{0,3,1}, '{2,0,1}, '{1,0,3}};

   function automatic int pos_of(int e);
      return (e / DIV) % 600;
   endfunction

   function automatic int raw_of(int pos, int ch);
      int s, k, c;
      s = pos / 100;
      k = pos % 100;
      c = lv[s][ch];
      case (c)
         1: return 100;
         2: return k;
         3: return 100 - k;
         default: return 0;
      endcase
   endfunction

   function automatic int scale_of(int raw, int b);
      int bcl;
      bcl = (b > 100) ? 100 : b;
      return (raw * bcl) / 100;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: advance the reference with the inputs seen at this edge, then compare
   task automatic cyc();
      bit tk;
      @(posedge clk);
      if (!rst_n) begin
         ecnt  = 0;
         pend  = 1'b0;
         m_r   = 0; m_g = 0; m_b = 0;
         m_upd = 1'b0;
         prev_pos = 0;
      end else begin
         prev_pos = pos_of(ecnt);
         m_r   = scale_of(raw_of(prev_pos, 0), int'(bus.bright));
         m_g   = scale_of(raw_of(prev_pos, 1), int'(bus.bright));
         m_b   = scale_of(raw_of(prev_pos, 2), int'(bus.bright));
         m_upd = pend;
         tk    = bus.en && ((ecnt % DIV) == DIV - 1);
         if (bus.restart) begin
            ecnt = 0;
            pend = 1'b0;
         end else begin
            if (bus.en) ecnt++;
            pend = tk;
         end
      end
      #1;
      chk("duty_r", int'(bus.duty_r), m_r);
      chk("duty_g", int'(bus.duty_g), m_g);
      chk("duty_b", int'(bus.duty_b), m_b);
      chk("seg",    int'(bus.seg),    rst_n ? pos_of(ecnt) / 100 : 0);
      chk("upd",    int'(bus.upd),    int'(m_upd));
   endtask

   task automatic release_check();
      int n;
      bus.bright  = 7'd100;
      bus.en      = 1'b1;
      bus.restart = 1'b0;
      rst_n       = 1'b1;
      cyc();
      chk("rel_first_r", int'(bus.duty_r), 100);
      chk("rel_first_g", int'(bus.duty_g), 0);
      chk("rel_first_b", int'(bus.duty_b), 0);
      n = 1;
      while (bus.upd !== 1'b1 && n < 30) begin
         cyc();
         n++;
      end
      chk("first_upd_cycle", n, 11);
      chk("first_upd_g", int'(bus.duty_g), 1);
   endtask

   task automatic do_restart();
      bus.restart = 1'b1;
      cyc();
      bus.restart = 1'b0;
   endtask

   initial begin
      int ups, gap, n;
      bus.en      = 1'b1;
      bus.restart = 1'b0;
      bus.bright  = 7'd100;

      // reset held, then release
      repeat (3) cyc();
      chk("reset_upd", int'(bus.upd), 0);
      release_check();

      // full wheel with constant spot checks and tick spacing
      ups = 0;
      gap = 0;
      n   = 0;
      while (ups < 600 && n < 6200) begin
         cyc();
         n++;
         gap++;
         if (bus.upd === 1'b1) begin
            chk("tick_gap", gap, 10);
            gap = 0;
            ups++;
            if (prev_pos == 100) begin
               chk("s1k0_r", int'(bus.duty_r), 100);
               chk("s1k0_g", int'(bus.duty_g), 100);
               chk("s1k0_b", int'(bus.duty_b), 0);
            end
            if (prev_pos == 300) begin
               chk("s3k0_r", int'(bus.duty_r), 0);
               chk("s3k0_g", int'(bus.duty_g), 100);
               chk("s3k0_b", int'(bus.duty_b), 100);
            end
            if (prev_pos == 550) begin
               chk("s5k50_r", int'(bus.duty_r), 100);
               chk("s5k50_g", int'(bus.duty_g), 0);
               chk("s5k50_b", int'(bus.duty_b), 50);
            end
         end
      end
      chk("wheel_ticks", ups, 600);
      chk("wheel_wrap_seg", int'(bus.seg), 0);

      // scaling at seg0 k=33, position frozen
      do_restart();
      n = 0;
      while (ecnt < 330 && n < 400) begin cyc(); n++; end
      chk("reach_k33", ecnt, 330);
      bus.en = 1'b0;
      cyc();
      cyc();
      bus.bright = 7'd50;
      cyc();
      chk("b50_r", int'(bus.duty_r), 50);
      chk("b50_g", int'(bus.duty_g), 16);
      chk("b50_b", int'(bus.duty_b), 0);
      chk("b50_upd", int'(bus.upd), 0);
      bus.bright = 7'd127;
      cyc();
      chk("b127_r", int'(bus.duty_r), 100);
      chk("b127_g", int'(bus.duty_g), 33);
      chk("b127_upd", int'(bus.upd), 0);
      bus.bright = 7'd0;
      cyc();
      chk("b0_r", int'(bus.duty_r), 0);
      chk("b0_g", int'(bus.duty_g), 0);
      chk("b0_upd", int'(bus.upd), 0);
      bus.bright = 7'd100;

      // enable hold at prescaler count 4
      bus.en = 1'b1;
      n = 0;
      while ((ecnt % DIV) != 4 && n < 20) begin cyc(); n++; end
      chk("reach_pcnt4", ecnt % DIV, 4);
      bus.en = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 35; i++) begin
         cyc();
         chk("hold_no_upd", int'(bus.upd), 0);
      end
      bus.en = 1'b1;
      n = 0;
      while (bus.upd !== 1'b1 && n < 30) begin cyc(); n++; end
      chk("resume_upd_edge", n, 7);

      // restart coincident with the tick at seg2 k=99
      do_restart();
      n = 0;
      while (ecnt < 2999 && n < 3100) begin cyc(); n++; end
      chk("reach_s2k99", ecnt, 2999);
      bus.restart = 1'b1;
      cyc();
      bus.restart = 1'b0;
      chk("rst_pri_seg", int'(bus.seg), 0);
      chk("rst_pri_upd0", int'(bus.upd), 0);
      cyc();
      chk("rst_pri_r", int'(bus.duty_r), 100);
      chk("rst_pri_g", int'(bus.duty_g), 0);
      chk("rst_pri_b", int'(bus.duty_b), 0);
      chk("rst_pri_upd1", int'(bus.upd), 0);
      cyc();
      chk("rst_pri_upd2", int'(bus.upd), 0);

      // asynchronous reset in the middle of seg4
      n = 0;
      while (pos_of(ecnt) < 420 && n < 4500) begin cyc(); n++; end
      chk("reach_seg4", int'(bus.seg), 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_r", int'(bus.duty_r), 0);
      chk("async_g", int'(bus.duty_g), 0);
      chk("async_b", int'(bus.duty_b), 0);
      chk("async_seg", int'(bus.seg), 0);
      chk("async_upd", int'(bus.upd), 0);
      repeat (2) cyc();
      release_check();

      // randomized run against the reference
      for (int i = 0; i < 3000; i++) begin
         bus.en      = ($urandom_range(0, 7) != 0);
         bus.restart = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) bus.bright = 7'($urandom_range(0, 127));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
